// File: rtl/out_display_pkg.sv
// out_display_pkg: shared FSM states, 7-segment patterns and decode helper
package out_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    // Iteration counter values for the 8-bit double-dabble
    localparam logic [3:0] ITER_LAST = 4'd7;
    localparam logic [3:0] ITER_IDLE = 4'd8;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/out_display_bin2bcd.sv
// out_bin2bcd: sequential 8-bit to 3-digit BCD double-dabble, one iteration per clock
module out_bin2bcd
    import out_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_bin,
    output logic        o_done,
    output logic [11:0] o_bcd
);

    logic [19:0] r_sr;
    logic [3:0]  r_cnt;
    logic [19:0] w_adj;

    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < 3; i++)
            if (r_sr[8+4*i +: 4] >= 4'd5) w_adj[8+4*i +: 4] = r_sr[8+4*i +: 4] + 4'd3;
    end

    // Counter parks at ITER_IDLE between conversions so no shifting happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= ITER_IDLE;
        end else if (i_start) begin
            r_sr  <= {12'd0, i_bin};
            r_cnt <= '0;
        end else if (r_cnt != ITER_IDLE) begin
            r_sr  <= w_adj << 1;
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_done = (r_cnt == ITER_LAST);
    assign o_bcd  = r_sr[19:8];

endmodule

// File: rtl/out_display.sv
// out_display: captures OUT bytes, converts to BCD and drives a multiplexed 3-digit 7-segment display
module out_display
    import out_display_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       out_strobe,
    input  logic [7:0] out_data,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy,
    output logic       shown
);

    localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

    state_t      r_state;
    state_t      w_next;
    logic        w_start;
    logic [7:0]  w_load;
    logic        w_done;
    logic [11:0] w_bcd;
    logic        w_strobe;
    logic        r_armed;
    logic        r_pend;
    logic [7:0]  r_pend_data;
    logic [11:0] r_dig;
    logic        r_shown;
    logic [15:0] r_div;
    logic [1:0]  r_idx;
    logic [3:0]  w_nib;
    logic [2:0]  w_an;
    logic [6:0]  w_pat;

    // First edge after reset release ignores the strobe
    assign w_strobe = out_strobe & r_armed;

    out_bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_bin   (w_load),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_load  = out_data;
        case (r_state)
            ST_IDLE: begin
                w_start = w_strobe;
                w_next  = w_strobe ? ST_CONV : ST_IDLE;
            end
            ST_CONV: w_next = w_done ? ST_COMMIT : ST_CONV;
            ST_COMMIT: begin
                w_start = w_strobe | r_pend;
                w_load  = w_strobe ? out_data : r_pend_data;
                w_next  = (w_strobe | r_pend) ? ST_CONV : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_dig       <= '0;
            r_shown     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (r_state == ST_COMMIT) begin
                r_dig   <= w_bcd;
                r_shown <= 1'b1;
                r_pend  <= 1'b0;
            end else if (r_state == ST_CONV && w_strobe) begin
                r_pend      <= 1'b1;
                r_pend_data <= out_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= 2'd2;
        end else if (r_div == DIV_MAX) begin
            r_div <= '0;
            r_idx <= (r_idx == 2'd0) ? 2'd2 : r_idx - 2'd1;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    assign w_nib = (r_idx == 2'd2) ? r_dig[11:8] : (r_idx == 2'd1) ? r_dig[7:4] : r_dig[3:0];
    assign w_an  = (r_idx == 2'd2) ? 3'b100 : (r_idx == 2'd1) ? 3'b010 : 3'b001;
    assign w_pat = r_shown ? seg_decode(w_nib) : SEG_BLANK;

    assign an    = r_shown ? w_an : 3'b000;
    assign seg   = SEG_ACTIVE_LOW ? ~w_pat : w_pat;
    assign busy  = (r_state != ST_IDLE);
    assign shown = r_shown;

endmodule

// File: tb/tb_out_display.sv
// tb_out_display: directed plus random OUT writes checked every cycle against a transaction-level display model
module tb_out_display;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       out_strobe = 1'b0;
    logic [7:0] out_data = 8'd0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;
    logic       shown;

    out_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_strobe (out_strobe),
        .out_data   (out_data),
        .seg        (seg),
        .an         (an),
        .busy       (busy),
        .shown      (shown)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: edges since reset release, conversion in flight, pending value, value on display
    int k;
    bit m_busy, m_pend, m_shown;
    int m_at, m_cur, m_pv, m_val;

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic model_reset();
        k = 0; m_busy = 0; m_pend = 0; m_shown = 0;
        m_at = 0; m_cur = 0; m_pv = 0; m_val = 0;
    endtask

    task automatic model_edge(input bit s, input int d);
        k++;
        if (m_busy && k == m_at) begin
            m_val = m_cur;
            m_shown = 1;
            if (s) begin m_cur = d; m_at = k + 9; end
            else if (m_pend) begin m_cur = m_pv; m_at = k + 9; end
            else m_busy = 0;
            m_pend = 0;
        end else if (m_busy) begin
            if (s) begin m_pend = 1; m_pv = d; end
        end else if (s) begin
            m_busy = 1; m_cur = d; m_at = k + 9;
        end
    endtask

    task automatic check();
        int idx, dg;
        logic [2:0] e_an;
        logic [6:0] e_seg;
        idx = 2 - (k / SD) % 3;
        dg = (idx == 2) ? m_val / 100 : (idx == 1) ? (m_val / 10) % 10 : m_val % 10;
        e_an = m_shown ? 3'(1 << idx) : 3'b000;
        e_seg = m_shown ? ~pat[dg] : 7'h7F;
        n_cmp++;
        assert (an === e_an) else begin n_fail++; $error("FAIL an k=%0d got %b exp %b", k, an, e_an); end
        n_cmp++;
        assert (seg === e_seg) else begin n_fail++; $error("FAIL seg k=%0d got %h exp %h", k, seg, e_seg); end
        n_cmp++;
        assert (busy === m_busy) else begin n_fail++; $error("FAIL busy k=%0d got %b exp %b", k, busy, m_busy); end
        n_cmp++;
        assert (shown === m_shown) else begin n_fail++; $error("FAIL shown k=%0d got %b exp %b", k, shown, m_shown); end
    endtask

    task automatic cyc(input bit s, input logic [7:0] d);
        out_strobe = s;
        out_data = d;
        @(posedge clk);
        model_edge(s, int'(d));
        #1;
        check();
        out_strobe = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check();
        repeat (3) @(posedge clk);
        #1;
        check();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        repeat (5000) cyc(1'b0, 8'h00);
        // 173 -> 1,7,3
        cyc(1'b1, 8'hAD);
        repeat (30) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h00);
        repeat (20) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hFF);
        repeat (20) cyc(1'b0, 8'h00);
        // Overrun: 52 is overwritten by 86 before it can start
        cyc(1'b1, 8'h12);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h34);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h56);
        repeat (30) cyc(1'b0, 8'h00);
        // Strobe on the commit edge of 200
        cyc(1'b1, 8'd200);
        repeat (8) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'd9);
        repeat (30) cyc(1'b0, 8'h00);
        // Reset mid-conversion, after a fresh reset so nothing is shown yet
        do_reset();
        repeat (5) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h99);
        repeat (3) cyc(1'b0, 8'h00);
        do_reset();
        repeat (30) cyc(1'b0, 8'h00);
        // Random traffic with dense and sparse strobes
        repeat (1500) cyc($urandom_range(0, 3) == 0, 8'($urandom));
        repeat (300) cyc($urandom_range(0, 1) == 0, 8'($urandom));
        repeat (30) cyc(1'b0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
